fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage WISC pipeline; sits directly upstream of decode.
- Owns the PC register and the instruction-memory request/acknowledge handshake.
- Drives the IF/ID pipeline latch that supplies decode with InstIn/pcplus2In.
- Accepts redirects (pcbranch/branch) and the hazard-unit stall; halts fetch after a HALT opcode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INST, 16'h0800, bubble instruction written into IF/ID on flush or empty slot.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset.
imem_addr  out  16  fetch address (current PC, bit0 forced 0).
imem_req  out  1  fetch request; held with imem_addr stable until imem_ack.
imem_rdata  in  16  instruction word, valid when imem_ack=1.
imem_ack  in  1  request complete; may assert in the same cycle as imem_req (zero-wait).
imem_err  in  1  memory fault, sampled with imem_ack.
stall  in  1  hazard unit: hold IF/ID and do not advance.
branch  in  1  redirect request from decode.
pcbranch  in  16  redirect target from decode.
InstOut  out  16  IF/ID instruction to decode.
pcplus2Out  out  16  IF/ID PC+2 of InstOut.
valid  out  1  IF/ID holds a real (non-bubble) instruction.
halted  out  1  fetch stopped after a HALT or fault.
err  out  1  sticky memory-fault flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC, state=REQ, imem_req=0.
  - InstOut=NOP_INST, pcplus2Out=0, valid=0, halted=0, err=0, hold buffer=0.
  - imem_req rises in the first cycle after rst deasserts.
  - Reset asserted mid-request abandons the request; no ack is awaited afterwards.
- State REQ:
  - Outputs: imem_req=1, imem_addr=PC.
  - ack, stall=0, branch=0: IF/ID<={imem_rdata, PC+2}, valid=1, PC<=PC+2. Throughput is 1 instruction per cycle.
    - imem_rdata[15:11]==5'b00000 (HALT): go to HALT; the HALT word itself is delivered to IF/ID.
    - Otherwise stay in REQ.
  - ack, stall=1: buffer<=imem_rdata, PC<=PC+2, go to HOLD. IF/ID is unchanged.
  - no ack, stall=0, branch=0: IF/ID<=NOP_INST, valid=0 (bubble).
  - no ack, stall=1: IF/ID held; keep requesting.
  - branch=1, stall=0:
    - PC<={pcbranch[15:1],1'b0}; IF/ID<=NOP_INST, valid=0.
    - Same-cycle ack: data discarded; stay in REQ at the new PC.
    - No ack yet: go to DROP.
- State HOLD:
  - Outputs: imem_req=0.
  - stall=1: hold everything.
  - stall=0, branch=0: IF/ID<={buffer, PC}, valid=1. Go to HALT if the buffer opcode is HALT, else REQ.
  - stall=0, branch=1: discard buffer, redirect PC, IF/ID<=bubble, go to REQ.
- State DROP:
  - Outputs: imem_req=1, imem_addr=old address (held stable per handshake).
  - On ack: data discarded, go to REQ at the redirected PC.
  - IF/ID gets bubbles unless stall=1.
  - A further branch in DROP overwrites the redirect PC.
- State HALT:
  - Outputs: imem_req=0, halted=1; IF/ID gets bubbles (held if stall=1).
  - branch=1 with stall=0 (an older instruction redirects): HALT is squashed, halted<=0, PC redirected, go to REQ.
  - Otherwise remain until reset.
- Fault: ack with imem_err=1 overrides the instruction.
  - IF/ID<=bubble, err<=1 (sticky), go to HALT.
  - A later branch does not leave HALT while err=1.
- Priority and gating:
  - Rule: rst > imem_err > branch > stall > normal advance.
  - branch is ignored while stall=1.
- Arithmetic: PC+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000. No carry out or error.
- pcplus2Out always equals the fetched address+2 of InstOut; it is held with InstOut on stall.

Test Plan:
- Reset release, zero-wait memory returning 0x4000,0x4100,0x4200 -> imem_addr 0,2,4 on consecutive cycles; InstOut matches one cycle later with pcplus2Out 2,4,6; valid=1.
- 3-cycle ack latency -> imem_addr held stable for 3 cycles; two bubbles (InstOut=0x0800, valid=0) precede the instruction.
- stall=1 for 2 cycles arriving with ack at PC=0x0010 -> IF/ID held, imem_req=0. After release InstOut=word@0x0010, pcplus2Out=0x0012, next imem_addr=0x0012.
- branch=1, pcbranch=0x0101 while a request to 0x0020 is outstanding -> bubble, DROP until ack (data discarded), next imem_addr=0x0100.
- HALT word (0x0000) fetched at 0x0030 -> delivered with valid=1, halted=1, imem_req=0. A subsequent branch to 0x0040 -> halted=0, fetch resumes at 0x0040.
- PC=0xFFFE fetch -> next imem_addr=0x0000. Separately, ack with imem_err=1 -> err=1, halted=1, bubble; a later branch is ignored.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/ack, decode redirect/stall, and the IF/ID latch outputs.
// master = fetch stage side; slave = memory/decode/hazard side.
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        imem_err;
  logic        stall;
  logic        branch;
  logic [15:0] pcbranch;
  logic [15:0] InstOut;
  logic [15:0] pcplus2Out;
  logic        valid;
  logic        halted;
  logic        err;

  modport master (
    output imem_addr, imem_req, InstOut, pcplus2Out, valid, halted, err,
    input  imem_rdata, imem_ack, imem_err, stall, branch, pcbranch
  );

  modport slave (
    input  imem_addr, imem_req, InstOut, pcplus2Out, valid, halted, err,
    output imem_rdata, imem_ack, imem_err, stall, branch, pcbranch
  );
endinterface

// File: rtl/fetch_stage.sv
// WISC fetch stage: owns PC, imem req/ack handshake and the IF/ID latch; one instruction per cycle on zero-wait memory.
// Stall parks an arriving word in a one-entry hold buffer; redirects mid-request wait out the old ack in DROP.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]  r_state,     w_state_nxt;
  logic [15:0] r_pc,        w_pc_nxt;
  logic [15:0] r_drop_addr, w_drop_addr_nxt;
  logic [15:0] r_buf,       w_buf_nxt;
  logic [15:0] r_inst,      w_inst_nxt;
  logic [15:0] r_pcp2,      w_pcp2_nxt;
  logic        r_valid,     w_valid_nxt;
  logic        r_halted,    w_halted_nxt;
  logic        r_err,       w_err_nxt;

  logic [15:0] w_pc_inc;
  logic [15:0] w_target;
  logic        w_ack;
  logic        w_redirect;
  logic        w_fault;
  logic        w_rdata_halt;
  logic        w_buf_halt;

  assign w_pc_inc     = r_pc + 16'd2;
  assign w_target     = bus.pcbranch & 16'hFFFE;
  assign w_ack        = bus.imem_ack;
  assign w_redirect   = bus.branch & ~bus.stall;
  assign w_fault      = bus.imem_ack & bus.imem_err;
  assign w_rdata_halt = (bus.imem_rdata[15:11] == 5'b00000);
  assign w_buf_halt   = (r_buf[15:11] == 5'b00000);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_addr_nxt = r_drop_addr;
    w_buf_nxt       = r_buf;
    w_inst_nxt      = r_inst;
    w_pcp2_nxt      = r_pcp2;
    w_valid_nxt     = r_valid;
    w_halted_nxt    = r_halted;
    w_err_nxt       = r_err;

    case (r_state)
      S_REQ: begin
        if (w_fault) begin
          w_inst_nxt   = NOP_INST;
          w_valid_nxt  = 1'b0;
          w_err_nxt    = 1'b1;
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end else if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
          if (!w_ack) begin
            // The old request must still complete at its original address.
            w_drop_addr_nxt = r_pc & 16'hFFFE;
            w_state_nxt     = S_DROP;
          end
        end else if (bus.stall) begin
          if (w_ack) begin
            w_buf_nxt   = bus.imem_rdata;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_HOLD;
          end
        end else if (w_ack) begin
          w_inst_nxt  = bus.imem_rdata;
          w_pcp2_nxt  = w_pc_inc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
          if (w_rdata_halt) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end
        end else begin
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
        end
      end

      S_HOLD: begin
        if (!bus.stall) begin
          if (bus.branch) begin
            w_pc_nxt    = w_target;
            w_inst_nxt  = NOP_INST;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            // PC was already advanced when the word was parked, so it is the word's PC+2.
            w_inst_nxt  = r_buf;
            w_pcp2_nxt  = r_pc;
            w_valid_nxt = 1'b1;
            if (w_buf_halt) begin
              w_halted_nxt = 1'b1;
              w_state_nxt  = S_HALT;
            end else begin
              w_state_nxt = S_REQ;
            end
          end
        end
      end

      S_DROP: begin
        if (w_fault) begin
          w_inst_nxt   = NOP_INST;
          w_valid_nxt  = 1'b0;
          w_err_nxt    = 1'b1;
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end else begin
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end
          if (w_ack) begin
            w_state_nxt = S_REQ;
          end
          if (!bus.stall) begin
            w_inst_nxt  = NOP_INST;
            w_valid_nxt = 1'b0;
          end
        end
      end

      S_HALT: begin
        if (w_redirect && !r_err) begin
          w_halted_nxt = 1'b0;
          w_pc_nxt     = w_target;
          w_inst_nxt   = NOP_INST;
          w_valid_nxt  = 1'b0;
          w_state_nxt  = S_REQ;
        end else if (!bus.stall) begin
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_drop_addr <= 16'h0000;
      r_buf       <= 16'h0000;
      r_inst      <= NOP_INST;
      r_pcp2      <= 16'h0000;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
      r_buf       <= w_buf_nxt;
      r_inst      <= w_inst_nxt;
      r_pcp2      <= w_pcp2_nxt;
      r_valid     <= w_valid_nxt;
      r_halted    <= w_halted_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Gating with rst keeps the request low throughout reset, abandoning any in-flight fetch.
  assign bus.imem_req   = rst & ((r_state == S_REQ) | (r_state == S_DROP));
  assign bus.imem_addr  = (r_state == S_DROP) ? r_drop_addr : (r_pc & 16'hFFFE);
  assign bus.InstOut    = r_inst;
  assign bus.pcplus2Out = r_pcp2;
  assign bus.valid      = r_valid;
  assign bus.halted     = r_halted;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction-memory responder, behavioural reference model and per-cycle compare.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic clk;
  logic rst;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 0;

  int          mem_wait  = 0;
  logic [15:0] halt_addr = 16'h0001;
  logic [15:0] err_addr  = 16'h0001;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return 16'h4000 | {2'b00, a[6:0], 7'b0000000};
  endfunction

  // Memory: acks each request after mem_wait cycles without ack.
  initial begin
    int cnt;
    cnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_err   = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (rst && bus.imem_req) begin
        if (cnt >= mem_wait) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          bus.imem_err   = (bus.imem_addr == err_addr);
          cnt = 0;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_err   = 1'b0;
          bus.imem_rdata = 16'hDEAD;
          cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        bus.imem_err = 1'b0;
        cnt = 0;
      end
    end
  end

  // Reference model: fetch pointer, optional parked word, pending wrong-path fetch, halt/fault flags.
  logic [15:0] m_pc, m_drop_addr, m_buf, m_inst, m_pcp2;
  bit m_have_buf, m_dropping, m_halted, m_err, m_valid;

  task automatic model_reset();
    m_pc = 16'h0000; m_drop_addr = 16'h0000; m_buf = 16'h0000;
    m_inst = NOP; m_pcp2 = 16'h0000; m_valid = 0;
    m_have_buf = 0; m_dropping = 0; m_halted = 0; m_err = 0;
  endtask

  task automatic bubble();
    m_inst = NOP; m_valid = 0;
  endtask

  task automatic deliver(input logic [15:0] w, input logic [15:0] p2);
    m_inst = w; m_pcp2 = p2; m_valid = 1;
    if (w[15:11] == 5'b00000) m_halted = 1;
  endtask

  task automatic model_step();
    bit ack, ferr, st, br;
    logic [15:0] tgt, rd;
    ack  = bus.imem_ack;
    ferr = bus.imem_ack && bus.imem_err;
    st   = bus.stall;
    br   = bus.branch && !bus.stall;
    tgt  = bus.pcbranch & 16'hFFFE;
    rd   = bus.imem_rdata;
    if (m_halted) begin
      if (br && !m_err) begin m_halted = 0; m_pc = tgt; bubble(); end
      else if (!st) bubble();
    end else if (m_have_buf) begin
      if (!st) begin
        m_have_buf = 0;
        if (bus.branch) begin m_pc = tgt; bubble(); end
        else deliver(m_buf, m_pc);
      end
    end else if (ferr) begin
      bubble(); m_err = 1; m_halted = 1; m_dropping = 0;
    end else if (br) begin
      if (!ack && !m_dropping) m_drop_addr = m_pc;
      m_dropping = !ack;
      m_pc = tgt;
      bubble();
    end else if (m_dropping) begin
      if (ack) m_dropping = 0;
      if (!st) bubble();
    end else if (ack) begin
      if (st) begin m_buf = rd; m_have_buf = 1; end
      else deliver(rd, 16'(m_pc + 16'd2));
      m_pc = 16'(m_pc + 16'd2);
    end else if (!st) begin
      bubble();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    bit exp_req;
    forever begin
      @(negedge clk);
      #2;
      if (model_on) begin
        exp_req = rst && !m_halted && !m_have_buf;
        check("cmp_req", bus.imem_req, exp_req);
        if (exp_req) check("cmp_addr", bus.imem_addr, m_dropping ? m_drop_addr : m_pc);
        check("cmp_inst", bus.InstOut, m_inst);
        check("cmp_valid", bus.valid, m_valid);
        if (m_valid) check("cmp_pcplus2", bus.pcplus2Out, m_pcp2);
        check("cmp_halted", bus.halted, m_halted);
        check("cmp_err", bus.err, m_err);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.stall = 1'b0; bus.branch = 1'b0; bus.pcbranch = 16'h0000;
    model_on = 1;
    #1;
    check("rst_req", bus.imem_req, 16'd0);
    check("rst_inst", bus.InstOut, NOP);
    check("rst_pcplus2", bus.pcplus2Out, 16'd0);
    check("rst_valid", bus.valid, 16'd0);
    check("rst_halted", bus.halted, 16'd0);
    check("rst_err", bus.err, 16'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step(input bit s, input bit b, input logic [15:0] pcb);
    @(posedge clk);
    #1;
    bus.stall = s; bus.branch = b; bus.pcbranch = pcb;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.branch = 1'b0; bus.pcbranch = 16'h0000;

    // Zero-wait streaming
    do_reset();
    step(0, 0, 0); check("s1_addr0", bus.imem_addr, 16'h0000); check("s1_req", bus.imem_req, 16'd1);
    step(0, 0, 0); check("s1_inst0", bus.InstOut, 16'h4000); check("s1_pc2_0", bus.pcplus2Out, 16'h0002);
                   check("s1_valid", bus.valid, 16'd1); check("s1_addr1", bus.imem_addr, 16'h0002);
    step(0, 0, 0); check("s1_inst1", bus.InstOut, 16'h4100); check("s1_pc2_1", bus.pcplus2Out, 16'h0004);
    step(0, 0, 0); check("s1_inst2", bus.InstOut, 16'h4200); check("s1_pc2_2", bus.pcplus2Out, 16'h0006);

    // Slow memory; reset also abandons an in-flight request
    mem_wait = 2;
    do_reset();
    step(0, 0, 0); check("s2_addr_c1", bus.imem_addr, 16'h0000);
    step(0, 0, 0); check("s2_addr_c2", bus.imem_addr, 16'h0000); check("s2_bub1", bus.InstOut, NOP);
                   check("s2_bub1_v", bus.valid, 16'd0);
    step(0, 0, 0); check("s2_addr_c3", bus.imem_addr, 16'h0000); check("s2_bub2", bus.InstOut, NOP);
    step(0, 0, 0); check("s2_inst", bus.InstOut, 16'h4000); check("s2_next_addr", bus.imem_addr, 16'h0002);

    // Stall arriving with ack at 0x0010
    mem_wait = 0;
    do_reset();
    repeat (8) step(0, 0, 0);
    step(1, 0, 0); check("s3_addr", bus.imem_addr, 16'h0010); check("s3_inst_pre", bus.InstOut, 16'h4700);
    step(1, 0, 0); check("s3_req_hold", bus.imem_req, 16'd0); check("s3_inst_held", bus.InstOut, 16'h4700);
                   check("s3_pc2_held", bus.pcplus2Out, 16'h0010);
    step(0, 0, 0); check("s3_req_hold2", bus.imem_req, 16'd0);
    step(0, 0, 0); check("s3_inst", bus.InstOut, 16'h4800); check("s3_pc2", bus.pcplus2Out, 16'h0012);
                   check("s3_next_addr", bus.imem_addr, 16'h0012);

    // Branch while a request to 0x0020 is outstanding
    do_reset();
    step(0, 1, 16'h0020);
    mem_wait = 2;
    step(0, 1, 16'h0101);
    step(0, 0, 0); check("s4_drop_addr", bus.imem_addr, 16'h0020); check("s4_bubble", bus.valid, 16'd0);
    step(0, 0, 0); check("s4_drop_addr2", bus.imem_addr, 16'h0020);
    step(0, 0, 0); check("s4_new_addr", bus.imem_addr, 16'h0100); check("s4_inst", bus.InstOut, NOP);
    step(0, 0, 0);
    mem_wait = 0;

    // HALT at 0x0030, then redirect out
    halt_addr = 16'h0030;
    do_reset();
    step(0, 1, 16'h0030);
    step(0, 0, 0); check("s5_addr", bus.imem_addr, 16'h0030);
    step(0, 1, 16'h0040); check("s5_inst", bus.InstOut, 16'h0000); check("s5_valid", bus.valid, 16'd1);
                          check("s5_halted", bus.halted, 16'd1); check("s5_req", bus.imem_req, 16'd0);
    step(0, 0, 0); check("s5_resume_h", bus.halted, 16'd0); check("s5_resume_a", bus.imem_addr, 16'h0040);
    step(0, 0, 0);
    halt_addr = 16'h0001;

    // PC wrap
    do_reset();
    step(0, 1, 16'hFFFE);
    step(0, 0, 0); check("s6_addr", bus.imem_addr, 16'hFFFE);
    step(0, 0, 0); check("s6_inst", bus.InstOut, 16'h7F00); check("s6_pc2", bus.pcplus2Out, 16'h0000);
                   check("s6_wrap_addr", bus.imem_addr, 16'h0000);

    // Branch ignored while stalled
    do_reset();
    step(1, 1, 16'h0080);
    step(0, 0, 0); check("s7_req", bus.imem_req, 16'd0);
    step(0, 0, 0); check("s7_inst", bus.InstOut, 16'h4000); check("s7_addr", bus.imem_addr, 16'h0002);

    // Memory fault; later branch must not leave HALT
    err_addr = 16'h0050;
    do_reset();
    step(0, 1, 16'h0050);
    step(0, 0, 0); check("s8_addr", bus.imem_addr, 16'h0050);
    step(0, 1, 16'h0060); check("s8_err", bus.err, 16'd1); check("s8_halted", bus.halted, 16'd1);
                          check("s8_bubble", bus.InstOut, NOP);
    step(0, 0, 0); check("s8_still_halted", bus.halted, 16'd1); check("s8_req", bus.imem_req, 16'd0);
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
